// File: rtl/i2c_reg_slave.sv
// I2C write/read register target: decodes [SLAVE_ADDR, SUB_ADDR, DATA...] bursts into a local register file.
// Optional macro I2C_SLV_READ_EN builds the read path (RDATA/RDATA_ACK); otherwise read requests are NACKed.
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A,
    parameter int         REG_NUM    = 16,
    parameter logic [7:0] RESET_VAL  = 8'h00
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [7:0] iREG_ADDR,
    output logic [7:0] oREG_DATA,
    output logic       oWR_STB,
    output logic [7:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic       oBUSY
);
    localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WDATA,
`ifdef I2C_SLV_READ_EN
        RDATA,
        RDATA_ACK,
`endif
        WDATA_ACK
    } state_t;

    state_t     state, state_nx;
    logic       scl_p0, scl_p1, scl_p2, sda_p0, sda_p1, sda_p2;
    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic       byte_full, byte_full_nx;
    logic [7:0] shift, shift_nx, tx, tx_nx, pointer, pointer_nx, rd_byte;
    logic       sda_low, sda_low_nx, busy_nx, stb_nx, reg_we;
    logic [7:0] regs [REG_NUM];

    function automatic logic in_range(input logic [7:0] a);
        return int'(a) < REG_NUM;
    endfunction

    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

    // Stage p0/p1: bus synchronizer; p2: history flop for edge detection
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            {scl_p0, scl_p1, scl_p2} <= 3'b111;
            {sda_p0, sda_p1, sda_p2} <= 3'b111;
        end else begin
            {scl_p0, scl_p1, scl_p2} <= {I2C_SCLK, scl_p0, scl_p1};
            {sda_p0, sda_p1, sda_p2} <= {I2C_SDAT, sda_p0, sda_p1};
        end
    end

    assign scl_rise   =  scl_p1 & ~scl_p2;
    assign scl_fall   = ~scl_p1 &  scl_p2;
    assign start_cond =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_cond  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
    assign rd_byte    = in_range(pointer) ? regs[pointer[AW-1:0]] : 8'hFF;

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        byte_full_nx = byte_full;
        shift_nx     = shift;
        tx_nx        = tx;
        pointer_nx   = pointer;
        sda_low_nx   = sda_low;
        busy_nx      = oBUSY;
        stb_nx       = 1'b0;
        reg_we       = 1'b0;
        if (start_cond) begin
            state_nx     = ADDR;
            bit_cnt_nx   = 3'd0;
            byte_full_nx = 1'b0;
            sda_low_nx   = 1'b0;
            busy_nx      = 1'b0;
        end else if (stop_cond) begin
            state_nx     = IDLE;
            byte_full_nx = 1'b0;
            sda_low_nx   = 1'b0;
            busy_nx      = 1'b0;
        end else begin
            case (state)
                ADDR, SUB, WDATA: begin
                    if (scl_rise && !byte_full) begin
                        shift_nx   = {shift[6:0], sda_p1};
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_full_nx = 1'b1;
                            if (state == ADDR) begin
`ifdef I2C_SLV_READ_EN
                                if (shift_nx[7:1] != SLAVE_ADDR) begin
`else
                                if (shift_nx[7:1] != SLAVE_ADDR || shift_nx[0]) begin
`endif
                                    state_nx     = IDLE;
                                    byte_full_nx = 1'b0;
                                end else begin
                                    busy_nx = 1'b1;
                                end
                            end
                        end
                    end else if (scl_fall && byte_full) begin
                        // Completed byte: ACK drive starts on this SCL fall
                        byte_full_nx = 1'b0;
                        sda_low_nx   = 1'b1;
                        if (state == ADDR) begin
                            state_nx = ADDR_ACK;
                        end else if (state == SUB) begin
                            pointer_nx = shift;
                            state_nx   = SUB_ACK;
                        end else begin
                            stb_nx     = 1'b1;
                            reg_we     = in_range(pointer);
                            pointer_nx = pointer + 8'd1;
                            state_nx   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_low_nx = 1'b0;
                        bit_cnt_nx = 3'd0;
                        state_nx   = SUB;
`ifdef I2C_SLV_READ_EN
                        if (shift[0]) begin
                            state_nx   = RDATA;
                            tx_nx      = rd_byte;
                            sda_low_nx = ~rd_byte[7];
                        end
`endif
                    end
                end
                SUB_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_low_nx = 1'b0;
                        bit_cnt_nx = 3'd0;
                        state_nx   = WDATA;
                    end
                end
`ifdef I2C_SLV_READ_EN
                RDATA: begin
                    if (scl_rise && !byte_full) begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_full_nx = 1'b1;
                            pointer_nx   = pointer + 8'd1;
                        end
                    end else if (scl_fall) begin
                        if (byte_full) begin
                            byte_full_nx = 1'b0;
                            sda_low_nx   = 1'b0;
                            state_nx     = RDATA_ACK;
                        end else begin
                            tx_nx      = {tx[6:0], 1'b0};
                            sda_low_nx = ~tx[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    // byte_full doubles as "master ACK seen, next fall starts a byte"
                    if (scl_rise && !byte_full) begin
                        if (sda_p1) begin
                            state_nx = IDLE;
                            busy_nx  = 1'b0;
                        end else begin
                            byte_full_nx = 1'b1;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_nx = 1'b0;
                        bit_cnt_nx   = 3'd0;
                        tx_nx        = rd_byte;
                        sda_low_nx   = ~rd_byte[7];
                        state_nx     = RDATA;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            shift     <= 8'h00;
            tx        <= 8'h00;
            pointer   <= 8'h00;
            sda_low   <= 1'b0;
            oBUSY     <= 1'b0;
            oWR_STB   <= 1'b0;
            oWR_ADDR  <= 8'h00;
            oWR_DATA  <= 8'h00;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            byte_full <= byte_full_nx;
            shift     <= shift_nx;
            tx        <= tx_nx;
            pointer   <= pointer_nx;
            sda_low   <= sda_low_nx;
            oBUSY     <= busy_nx;
            oWR_STB   <= stb_nx;
            if (stb_nx) begin
                oWR_ADDR <= pointer;
                oWR_DATA <= shift;
            end
        end
    end

    // Register file and host readback; a same-cycle write is not forwarded
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= RESET_VAL;
            oREG_DATA <= 8'h00;
        end else begin
            if (reg_we) regs[pointer[AW-1:0]] <= shift;
            oREG_DATA <= in_range(iREG_ADDR) ? regs[iREG_ADDR[AW-1:0]] : 8'hFF;
        end
    end
endmodule
